// File: rtl/ahb_pixpos_pkg.sv
// Shared constants for the AHB pixel-position queue: register word indices,
// CTRL/STATUS bit positions and reset colours.
package ahb_pixpos_pkg;

  localparam logic [3:0] W_PUSH   = 4'd4;
  localparam logic [3:0] W_BG     = 4'd5;
  localparam logic [3:0] W_POINT  = 4'd6;
  localparam logic [3:0] W_CTRL   = 4'd7;
  localparam logic [3:0] W_STATUS = 4'd8;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_COUNT = 8;

  localparam logic [23:0] RST_BG      = 24'h0000c3;
  localparam logic [23:0] RST_POINT   = 24'h000fff;
  localparam logic        RST_SW_CTRL = 1'b1;

  // Packed so bit0 = sw, bit1 = frame-sync commit, bit2 = irq-on-empty.
  typedef struct packed {
    logic irq_en;
    logic sync;
    logic sw;
  } ctrl_t;

endpackage

// File: rtl/ahb_pixpos_queue_if.sv
// AHB-Lite slave bus bundle for the pixel-position queue.
interface ahb_pixpos_queue_if;
  logic        HSEL;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (output HSEL, HREADY, HWRITE, HADDR, HTRANS, HWDATA,
                  input  HRDATA, HREADYOUT);
  modport slave  (input  HSEL, HREADY, HWRITE, HADDR, HTRANS, HWDATA,
                  output HRDATA, HREADYOUT);
endinterface

// File: rtl/pixpos_fifo.sv
// First-word-fall-through FIFO with power-of-two depth; a push into a full
// FIFO succeeds only when a pop happens in the same cycle.
module pixpos_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone decide
  // which entries are live, so the array maps onto plain RAM.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ahb_pixpos_queue.sv
// AHB-Lite register block feeding a position FIFO, with shadowed colours
// that commit either immediately or on frame_start.
module ahb_pixpos_queue
  import ahb_pixpos_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int CW    = 11,
  parameter int DEPTH = 8,
  parameter int COLW  = 12
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_pixpos_queue_if.slave   bus,
  input  logic                frame_start,
  output logic                pos_valid,
  input  logic                pos_ready,
  output logic [NCH*CW-1:0]   pos_data,
  output logic [COLW-1:0]     background,
  output logic [COLW-1:0]     point,
  output logic                sw_ctrl,
  output logic                irq
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]        addr_q;
  logic              wr_q;
  logic [CW-1:0]     stage [NCH];
  logic [COLW-1:0]   bg_sh, pt_sh;
  ctrl_t             ctrl;
  logic              ovf;
  logic              push;
  logic [NCH*CW-1:0] push_data;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic [31:0]       rdata;
  logic              unused_bits;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (bus.HREADY) begin
      addr_q <= bus.HADDR[5:2];
      wr_q   <= bus.HSEL & bus.HWRITE & bus.HTRANS[1];
    end
  end

  assign push = wr_q && (addr_q == W_PUSH);

  // NOTE: default assigned first so no path through the block infers a latch.
  always_comb begin
    push_data = '0;
    for (int n = 0; n < NCH; n++) push_data[n*CW +: CW] = stage[n];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int n = 0; n < NCH; n++) stage[n] <= '0;
      bg_sh <= RST_BG[COLW-1:0];
      pt_sh <= RST_POINT[COLW-1:0];
      ctrl  <= '{irq_en: 1'b0, sync: 1'b0, sw: RST_SW_CTRL};
    end else if (wr_q) begin
      for (int n = 0; n < NCH; n++)
        if (addr_q == 4'(n)) stage[n] <= bus.HWDATA[CW-1:0];
      case (addr_q)
        W_BG:    bg_sh <= bus.HWDATA[COLW-1:0];
        W_POINT: pt_sh <= bus.HWDATA[COLW-1:0];
        W_CTRL:  ctrl  <= ctrl_t'(bus.HWDATA[2:0]);
        default: ;
      endcase
    end
  end

  // Actives load the pre-write shadow, so a write landing on frame_start
  // waits for the following frame.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      background <= RST_BG[COLW-1:0];
      point      <= RST_POINT[COLW-1:0];
    end else if (!ctrl.sync || frame_start) begin
      background <= bg_sh;
      point      <= pt_sh;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_q && addr_q == W_STATUS) ovf <= 1'b0;
      else if (push && fifo_full && !pos_ready) ovf <= 1'b1;
      irq <= (ctrl.irq_en & fifo_empty) | ovf;
    end
  end

  pixpos_fifo #(.WIDTH(NCH*CW), .DEPTH(DEPTH)) u_fifo (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .push      (push),
    .push_data (push_data),
    .pop       (pos_ready),
    .head      (pos_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pos_valid = ~fifo_empty;
  assign sw_ctrl   = ctrl.sw;

  always_comb begin
    rdata = '0;
    for (int n = 0; n < NCH; n++)
      if (addr_q == 4'(n)) rdata[CW-1:0] = stage[n];
    case (addr_q)
      W_BG:    rdata[COLW-1:0] = bg_sh;
      W_POINT: rdata[COLW-1:0] = pt_sh;
      W_CTRL:  rdata[2:0]      = ctrl;
      W_STATUS: begin
        rdata[ST_EMPTY]          = fifo_empty;
        rdata[ST_FULL]           = fifo_full;
        rdata[ST_OVF]            = ovf;
        rdata[ST_COUNT +: AW+1]  = fifo_count;
      end
      default: ;
    endcase
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign unused_bits   = ^{bus.HADDR[31:6], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

endmodule

// File: doc/ahb_pixpos_queue.md
AHB_PIXPOS_QUEUE -- requirements
Module: ahb_pixpos_queue

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 NCH, default 3: coordinate channels per entry, legal range 1..4.
REQ-003 CW, default 11: coordinate width in bits, legal range 1..16.
REQ-004 DEPTH, default 8: FIFO entries; SHALL be a power of 2, minimum 2.
REQ-005 COLW, default 12: colour width in bits, legal range 1..24.
REQ-006 HCLK  in  1  bus and core clock.
REQ-007 HRESETn  in  1  asynchronous active-low reset.
REQ-008 HSEL, HREADY, HWRITE  in  1 each  AHB-Lite slave select, bus ready, write.
REQ-009 HADDR  in  32; HTRANS  in  2; HWDATA  in  32  AHB-Lite address, transfer type, write data.
REQ-010 HRDATA  out  32  read data; HREADYOUT  out  1  tied to 1 (zero wait states).
REQ-011 frame_start  in  1  one-cycle pulse at start of each display frame.
REQ-012 pos_valid  out  1; pos_ready  in  1  position-stream handshake.
REQ-013 pos_data  out  NCH*CW  FIFO head entry; channel 0 in the LSBs.
REQ-014 background, point  out  COLW each  active colours.
REQ-015 sw_ctrl  out  1  colour taken from switches when 1.
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 Address phase SHALL be captured when HREADY=1: word index HADDR[5:2] and write flag HSEL&HWRITE&HTRANS[1]; the write SHALL take effect in the data phase; HRDATA SHALL be combinational from the captured index, zero-extended.
REQ-018 Word map: 0..NCH-1 STAGE[n] (RW, CW bits); 4 PUSH (WO, reads 0); 5 BG shadow (RW); 6 POINT shadow (RW); 7 CTRL (RW; bit0 sw_ctrl, bit1 frame-sync commit, bit2 irq-on-empty enable); 8 STATUS (RO except bit2); unmapped indices SHALL read 0 and ignore writes.
REQ-019 STATUS bit0 empty, bit1 full, bit2 sticky overflow (cleared by any write to STATUS), bits[8+:clog2(DEPTH)+1] current count.
REQ-020 Any write to PUSH SHALL enqueue {STAGE[NCH-1..0]} on the following clock; STAGE registers SHALL remain unchanged.
REQ-021 The FIFO SHALL be first-word-fall-through: pos_valid = !empty, and pos_data = head entry.
REQ-022 A pop SHALL occur on the cycle where pos_valid & pos_ready; pos_data SHALL remain stable while pos_valid=1 and pos_ready=0.
REQ-023 Push while full without a same-cycle pop SHALL be dropped and SHALL set overflow; push and pop in the same cycle while full SHALL both succeed with count unchanged.
REQ-024 Push while empty SHALL set pos_valid the next cycle; a pop is impossible while empty.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 CTRL bit1=0: background/point SHALL equal their shadows one cycle after the shadow write.
REQ-027 CTRL bit1=1: actives SHALL load the shadows only on frame_start; when frame_start coincides with a shadow write, the actives SHALL load the pre-write shadow value, and the new value SHALL commit at the next frame_start.
REQ-028 irq SHALL be registered: (CTRL bit2 & empty) | overflow.

Reset
REQ-029 On HRESETn low, asynchronously: FIFO empty, pointers 0, overflow 0, STAGE 0, BG shadow and background 12'h0c3, POINT shadow and point 12'hfff, sw_ctrl 1, CTRL bits1-2 0, captured address/write flag 0, irq 0.
REQ-030 Reset mid-transfer SHALL discard the pending write and all queued entries; no output SHALL glitch on reset release.

Structure
REQ-031 Package ahb_pixpos_pkg SHALL hold the word-index constants, the STATUS bit positions, and the reset colour and sw_ctrl values.
REQ-032 FIFO storage and pointers SHALL be a sub-module pixpos_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-033 Write STAGE 5/6/7, PUSH, pos_ready=0 -> pos_valid=1 next cycle, pos_data={7,6,5}, held stable; pos_ready=1 -> pop, pos_valid=0.
REQ-034 DEPTH=8: 9 PUSHes, no pops -> STATUS full=1, count=8, overflow=1, irq=1; write STATUS -> overflow=0; the 8 pops return the first 8 entries in order.
REQ-035 Full FIFO, PUSH with pos_ready=1 in the same cycle -> count stays 8, no overflow, new entry last.
REQ-036 CTRL=0x3, write BG=0x0f0 coincident with frame_start -> background stays 0x0c3 and becomes 0x0f0 at the next frame_start; CTRL=0x1 -> background follows BG one cycle after the write.
REQ-037 Assert HRESETn low mid-burst with 3 entries queued -> pos_valid=0, background=0x0c3, point=0xfff, sw_ctrl=1 immediately, without waiting for a clock edge.
